// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit, one result bit per cycle
module mult_div_unit #(
    parameter int WIDTH      = 32,
    parameter int COUNT_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_BITS-1:0]  count;
    logic                   is_div;
    logic                   b_zero;
    logic                   neg_main;   // product sign, or quotient sign for divide
    logic                   neg_rem;    // remainder follows the dividend's sign
    logic [WIDTH-1:0]       a_raw;      // dividend as issued, returned in hi on divide by zero
    logic [WIDTH-1:0]       oper;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     acc_step;
    logic                   last_step;

    logic                   signed_op;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;

    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_trial;
    logic [WIDTH+1:0]       div_diff;

    logic [2*WIDTH-1:0]     prod_fixed;
    logic [WIDTH-1:0]       quot_fixed;
    logic [WIDTH-1:0]       rem_fixed;
    logic [WIDTH-1:0]       res_hi;
    logic [WIDTH-1:0]       res_lo;

    assign last_step = (count == COUNT_BITS'(WIDTH - 1));

    // Operand magnitudes for signed ops; unsigned ops pass straight through
    always_comb begin
        signed_op = ~op[0];
        mag_a     = (signed_op && operandA[WIDTH-1]) ? -operandA : operandA;
        mag_b     = (signed_op && operandB[WIDTH-1]) ? -operandB : operandB;
    end

    // One iteration: shift-add multiply or restoring divide on the shared accumulator
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : {(WIDTH+1){1'b0}});
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_trial} - {2'b00, oper};
        if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override of the finished magnitudes
    always_comb begin
        prod_fixed = neg_main ? -acc : acc;
        quot_fixed = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            res_hi = prod_fixed[2*WIDTH-1:WIDTH];
            res_lo = prod_fixed[WIDTH-1:0];
        end else if (b_zero) begin
            res_hi = a_raw;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_hi = rem_fixed;
            res_lo = quot_fixed;
        end
    end

    // Next-state and busy decode
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand capture, iteration, result write-back and MTHI/MTLO
    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            is_div    <= 1'b0;
            b_zero    <= 1'b0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            a_raw     <= '0;
            oper      <= '0;
            acc       <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div    <= op[1];
                        b_zero    <= (operandB == '0);
                        neg_main  <= signed_op & (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
                        neg_rem   <= signed_op & operandA[WIDTH-1];
                        a_raw     <= operandA;
                        oper      <= op[1] ? mag_b : mag_a;
                        acc       <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        count     <= '0;
                        divByZero <= 1'b0;
                    end else begin
                        if (writeHi) begin
                            hi <= operandA;
                        end
                        if (writeLo) begin
                            lo <= operandA;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    if (!last_step) begin
                        count <= count + 1'b1;
                    end
                end
                S_FINISH: begin
                    hi        <= res_hi;
                    lo        <= res_lo;
                    done      <= 1'b1;
                    divByZero <= is_div & b_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        writeHi;
    logic        writeLo;
    logic        busy;
    logic        done;
    logic        divByZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int passed;

    mult_div_unit #(.WIDTH(32), .COUNT_BITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .writeHi   (writeHi),
        .writeLo   (writeLo),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: {hi,lo} from plain 64-bit arithmetic on the architectural operands
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur, u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        u  = '0;
        case (o)
            2'b00: u = sa * sb;
            2'b01: u = ua * ub;
            2'b10: begin
                if (b == 32'd0) begin
                    u = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    u = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) begin
                    u = {a, 32'hFFFF_FFFF};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    u  = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return u;
    endfunction

    // Issue one operation and check latency, busy window, hi/lo hold and result.
    // Returns in the done cycle so a following call starts back-to-back.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic wr_same_cycle, input string tag);
        logic [63:0] exp;
        logic [31:0] prev_hi, prev_lo;
        int          edges, busy_cnt;
        logic        hold_ok;
        exp = model(o, a, b);
        @(negedge clk);
        prev_hi  = hi;
        prev_lo  = lo;
        start    = 1'b1;
        op       = o;
        operandA = a;
        operandB = b;
        writeHi  = wr_same_cycle;
        writeLo  = wr_same_cycle;
        @(posedge clk);
        #1;
        start   = 1'b0;
        writeHi = 1'b0;
        writeLo = 1'b0;
        check({tag, "_dbz_clear"}, {63'd0, divByZero}, 64'd0);
        edges    = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
        check({tag, "_hilo"}, {hi, lo}, exp);
        check({tag, "_dbz"}, {63'd0, divByZero}, {63'd0, (o[1] && b == 32'd0)});
    endtask

    initial begin
        int          edges, done_cnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        total    = 0;
        passed   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        operandA = '0;
        operandB = '0;
        writeHi  = 1'b0;
        writeLo  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, divByZero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        @(posedge clk);
        #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, "divu_zero");
        check("divu_zero_const", {hi, lo, 31'd0, divByZero}, {64'h0000_1234_FFFF_FFFF, 32'd1});
        do_op(2'b11, 32'd17, 32'd5, 1'b0, "divu_after_zero");

        // Start and writeHi while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; operandA = 32'd5; operandB = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b11; operandA = 32'h0000_00AA; operandB = 32'd3; writeHi = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; writeHi = 1'b0;
        edges = 10;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("busy_prot_latency", 64'(edges), 64'd33);
        check("busy_prot_hilo", {hi, lo}, {32'd0, 32'd30});
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("busy_prot_no_second_done", 64'(done_cnt), 64'd0);

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; operandA = 32'hFFFF_FF9C; operandB = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_flags", {61'd0, busy, done, divByZero}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        writeLo = 1'b1; operandA = 32'h55;
        @(posedge clk);
        #1;
        writeLo = 1'b0;
        check("mtlo", {hi, lo}, {32'd0, 32'h55});
        writeHi = 1'b1; writeLo = 1'b1; operandA = 32'h77;
        @(posedge clk);
        #1;
        writeHi = 1'b0; writeLo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'h77, 32'h77});

        // start wins over MTHI/MTLO issued in the same cycle (hold check catches a write)
        do_op(2'b01, 32'd3, 32'd4, 1'b1, "start_beats_write");

        // Back-to-back: second start lands in the done cycle of the first
        do_op(2'b01, 32'd2, 32'd3, 1'b0, "b2b_first");
        do_op(2'b11, 32'd9, 32'd4, 1'b0, "b2b_second");
        check("b2b_second_const", {hi, lo}, {32'd1, 32'd2});

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) ra = 32'($urandom_range(0, 300)) - 32'd150;
            if (i % 4 == 2) rb = 32'($urandom_range(0, 20)) - 32'd10;
            do_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
